wired_cdb_arb_rr: RTL and testbench

//  Parametrised successor of the backend CDB arbiter: merges PORT_CNT execution-unit result

---
 rtl/wired_cdb_arb_rr.sv | 140 ++++++++++++++
 tb/tb_wired_cdb_arb_rr.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wired_cdb_arb_rr.sv
// Merges PORT_CNT result sources onto LANE_CNT CDB lanes (lane = low wid bits), round-robin + starvation escalation.
// Latency: grant is combinational in the request cycle, lane outputs are registered (1 cycle).
// Backpressure: none from the CDB; sources are held off via src_ready_o, and flush_i blocks all grants.
module wired_cdb_arb_rr #(
  parameter int PORT_CNT   = 5,
  parameter int LANE_CNT   = 2,
  parameter int ROB_LEN    = 6,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic [PORT_CNT-1:0]          src_valid_i,
  input  logic [PORT_CNT*ROB_LEN-1:0]  src_wid_i,
  input  logic [PORT_CNT*DATA_W-1:0]   src_data_i,
  output logic [PORT_CNT-1:0]          src_ready_o,
  output logic [LANE_CNT-1:0]          cdb_valid_o,
  output logic [LANE_CNT*ROB_LEN-1:0]  cdb_wid_o,
  output logic [LANE_CNT*DATA_W-1:0]   cdb_data_o
);

  localparam int LANE_LOG = (LANE_CNT > 1) ? $clog2(LANE_CNT) : 0;
  // Lane index carried with at least one bit so the single-lane build has no zero-width slice.
  localparam int LANE_IW  = (LANE_LOG > 0) ? LANE_LOG : 1;
  localparam int PTR_W    = $clog2(PORT_CNT);
  localparam int CNT_W    = $clog2(STARVE_LIM + 1);

  logic [LANE_IW-1:0]  src_lane [PORT_CNT];
  logic [PTR_W-1:0]    ptr_q    [LANE_CNT];
  logic [CNT_W-1:0]    cnt_q    [PORT_CNT];
  logic [PTR_W-1:0]    lane_src [LANE_CNT];
  logic [LANE_CNT-1:0] lane_gnt;
  logic [PORT_CNT-1:0] src_gnt;
  logic [PORT_CNT-1:0] starved;
  int                  idx;

  // Lane steering: the low wid bits select the ROB bank; a single lane takes everything.
  generate
    if (LANE_CNT > 1) begin : g_multi_lane
      for (genvar s = 0; s < PORT_CNT; s++) begin : g_lane
        assign src_lane[s] = src_wid_i[s*ROB_LEN +: LANE_IW];
      end
    end else begin : g_single_lane
      for (genvar s = 0; s < PORT_CNT; s++) begin : g_lane
        assign src_lane[s] = '0;
      end
    end
  endgenerate

  // A source is starved once it has waited STARVE_LIM cycles.
  always_comb begin
    starved = '0;
    for (int s = 0; s < PORT_CNT; s++) begin
      starved[s] = (int'(cnt_q[s]) >= STARVE_LIM);
    end
  end

  // Per-lane pick: round-robin from the lane pointer, overridden by the lowest-index starved requester.
  always_comb begin
    lane_gnt = '0;
    src_gnt  = '0;
    idx      = 0;
    for (int l = 0; l < LANE_CNT; l++) begin
      lane_src[l] = '0;
      if (rst_n && !flush_i) begin
        // Scan from farthest to nearest so the first requester at or after the pointer is kept.
        for (int k = PORT_CNT - 1; k >= 0; k--) begin
          idx = (int'(ptr_q[l]) + k) % PORT_CNT;
          if (src_valid_i[idx] && (int'(src_lane[idx]) == l)) begin
            lane_gnt[l] = 1'b1;
            lane_src[l] = PTR_W'(idx);
          end
        end
        // Highest to lowest so the lowest-index starved requester ends up winning.
        for (int s = PORT_CNT - 1; s >= 0; s--) begin
          if (src_valid_i[s] && (int'(src_lane[s]) == l) && starved[s]) begin
            lane_gnt[l] = 1'b1;
            lane_src[l] = PTR_W'(s);
          end
        end
      end
      if (lane_gnt[l]) begin
        src_gnt[lane_src[l]] = 1'b1;
      end
    end
  end

  assign src_ready_o = src_gnt;

  // Output stage: register the winner per lane; an idle lane drops valid but keeps its payload.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cdb_valid_o <= '0;
      cdb_wid_o   <= '0;
      cdb_data_o  <= '0;
    end else begin
      for (int l = 0; l < LANE_CNT; l++) begin
        cdb_valid_o[l] <= lane_gnt[l];
        if (lane_gnt[l]) begin
          cdb_wid_o[l*ROB_LEN +: ROB_LEN] <= src_wid_i[int'(lane_src[l])*ROB_LEN +: ROB_LEN];
          cdb_data_o[l*DATA_W +: DATA_W]  <= src_data_i[int'(lane_src[l])*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Round-robin pointers: move just past the winner; lanes without a grant (or flushed) hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int l = 0; l < LANE_CNT; l++) begin
        ptr_q[l] <= '0;
      end
    end else begin
      for (int l = 0; l < LANE_CNT; l++) begin
        if (lane_gnt[l]) begin
          ptr_q[l] <= PTR_W'((int'(lane_src[l]) + 1) % PORT_CNT);
        end
      end
    end
  end

  // Wait counters: clear on grant or idle, saturate at the limit, frozen during flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < PORT_CNT; s++) begin
        cnt_q[s] <= '0;
      end
    end else if (!flush_i) begin
      for (int s = 0; s < PORT_CNT; s++) begin
        if (!src_valid_i[s] || src_gnt[s]) begin
          cnt_q[s] <= '0;
        end else if (cnt_q[s] < CNT_W'(STARVE_LIM)) begin
          cnt_q[s] <= cnt_q[s] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wired_cdb_arb_rr.sv
// Bench for wired_cdb_arb_rr: three configurations (5x2 lim 8, 5x2 lim 2, 3x1 lim 2) under one clock.
// A behavioural arbitration model checks every cycle; hand tables and sequences cover named corners.
// Single-lane instance additionally runs an in-order scoreboard over a long random stream.
module tb_wired_cdb_arb_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [4:0]   vld  [3];
  logic [29:0]  wid  [3];
  logic [159:0] dat  [3];
  logic         fl   [3];
  logic [4:0]   done [3];

  logic [4:0]  rdy_a, rdy_s;
  logic [2:0]  rdy_c;
  logic [1:0]  cv_a, cv_s;
  logic [0:0]  cv_c;
  logic [11:0] cw_a, cw_s;
  logic [5:0]  cw_c;
  logic [63:0] cd_a, cd_s;
  logic [31:0] cd_c;

  int checks = 0;
  int errors = 0;

  wired_cdb_arb_rr #(.PORT_CNT(5), .LANE_CNT(2), .ROB_LEN(6), .DATA_W(32), .STARVE_LIM(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush_i(fl[0]), .src_valid_i(vld[0]), .src_wid_i(wid[0]),
    .src_data_i(dat[0]), .src_ready_o(rdy_a), .cdb_valid_o(cv_a), .cdb_wid_o(cw_a), .cdb_data_o(cd_a));

  wired_cdb_arb_rr #(.PORT_CNT(5), .LANE_CNT(2), .ROB_LEN(6), .DATA_W(32), .STARVE_LIM(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .flush_i(fl[1]), .src_valid_i(vld[1]), .src_wid_i(wid[1]),
    .src_data_i(dat[1]), .src_ready_o(rdy_s), .cdb_valid_o(cv_s), .cdb_wid_o(cw_s), .cdb_data_o(cd_s));

  wired_cdb_arb_rr #(.PORT_CNT(3), .LANE_CNT(1), .ROB_LEN(6), .DATA_W(32), .STARVE_LIM(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .flush_i(fl[2]), .src_valid_i(vld[2][2:0]), .src_wid_i(wid[2][17:0]),
    .src_data_i(dat[2][95:0]), .src_ready_o(rdy_c), .cdb_valid_o(cv_c), .cdb_wid_o(cw_c), .cdb_data_o(cd_c));

  // Uniform views of the three instances.
  logic [4:0]  o_rdy [3];
  logic [1:0]  o_cv  [3];
  logic [11:0] o_cw  [3];
  logic [63:0] o_cd  [3];
  assign o_rdy[0] = rdy_a;            assign o_rdy[1] = rdy_s;            assign o_rdy[2] = {2'b00, rdy_c};
  assign o_cv[0]  = cv_a;             assign o_cv[1]  = cv_s;             assign o_cv[2]  = {1'b0, cv_c};
  assign o_cw[0]  = cw_a;             assign o_cw[1]  = cw_s;             assign o_cw[2]  = {6'h00, cw_c};
  assign o_cd[0]  = cd_a;             assign o_cd[1]  = cd_s;             assign o_cd[2]  = {32'h0, cd_c};

  function automatic int np(input int i);  return (i == 2) ? 3 : 5; endfunction
  function automatic int nl(input int i);  return (i == 2) ? 1 : 2; endfunction
  function automatic int lim(input int i); return (i == 0) ? 8 : 2; endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_src(input int i, input int s, input logic v, input logic [5:0] w, input logic [31:0] d);
    vld[i][s]         = v;
    wid[i][s*6 +: 6]  = w;
    dat[i][s*32 +: 32] = d;
  endtask

  // ---------------- reference model (per instance, abstract state) ----------------
  int          m_ptr [3][2];
  int          m_cnt [3][5];
  logic [1:0]  e_cv  [3];
  logic [11:0] e_cw  [3];
  logic [63:0] e_cd  [3];
  logic [4:0]  p_wait [3];
  logic [29:0] p_wid  [3];

  task automatic monitor(input int i);
    int         gl [2];
    logic [4:0] g;
    int         d;
    int         bd;
    g = '0;
    chk($sformatf("cdb_valid_i%0d", i), 64'(o_cv[i]), 64'(e_cv[i]));
    chk($sformatf("cdb_wid_i%0d", i), 64'(o_cw[i]), 64'(e_cw[i]));
    chk($sformatf("cdb_data_i%0d", i), o_cd[i], e_cd[i]);
    for (int l = 0; l < 2; l++) gl[l] = -1;
    if (rst_n && !fl[i]) begin
      for (int l = 0; l < nl(i); l++) begin
        for (int s = 0; s < np(i); s++)
          if (gl[l] < 0 && vld[i][s] && (int'(wid[i][s*6 +: 6]) % nl(i)) == l && m_cnt[i][s] >= lim(i))
            gl[l] = s;
        if (gl[l] < 0) begin
          bd = 99;
          for (int s = 0; s < np(i); s++) begin
            d = (s - m_ptr[i][l] + np(i)) % np(i);
            if (vld[i][s] && (int'(wid[i][s*6 +: 6]) % nl(i)) == l && d < bd) begin
              bd = d;
              gl[l] = s;
            end
          end
        end
        if (gl[l] >= 0) g[gl[l]] = 1'b1;
      end
    end
    chk($sformatf("src_ready_i%0d", i), 64'(o_rdy[i]), 64'(g));
    for (int s = 0; s < np(i); s++)
      if (p_wait[i][s] && vld[i][s] && wid[i][s*6 +: 6] != p_wid[i][s*6 +: 6]) begin
        errors++;
        $display("FAIL wid_changed_while_waiting inst=%0d src=%0d", i, s);
      end
    p_wait[i] = vld[i] & ~g;
    p_wid[i]  = wid[i];
    if (!rst_n) begin
      for (int l = 0; l < 2; l++) m_ptr[i][l] = 0;
      for (int s = 0; s < 5; s++) m_cnt[i][s] = 0;
      e_cv[i] = '0; e_cw[i] = '0; e_cd[i] = '0;
    end else if (fl[i]) begin
      e_cv[i] = '0;
    end else begin
      for (int l = 0; l < nl(i); l++) begin
        if (gl[l] >= 0) begin
          e_cv[i][l]         = 1'b1;
          e_cw[i][l*6 +: 6]  = wid[i][gl[l]*6 +: 6];
          e_cd[i][l*32 +: 32] = dat[i][gl[l]*32 +: 32];
          m_ptr[i][l]        = (gl[l] + 1) % np(i);
        end else begin
          e_cv[i][l] = 1'b0;
        end
      end
      for (int s = 0; s < np(i); s++)
        if (!vld[i][s] || g[s]) m_cnt[i][s] = 0;
        else if (m_cnt[i][s] < lim(i)) m_cnt[i][s]++;
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) monitor(i);
  end

  // ---------------- single-lane scoreboard ----------------
  typedef struct packed { logic [5:0] w; logic [31:0] d; } res_t;
  res_t sb_q[$];
  res_t sb_e;

  always @(negedge clk) begin
    if (cv_c[0]) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected actual=%0h/%0h required=none", cw_c, cd_c);
      end else begin
        sb_e = sb_q.pop_front();
        checks--;
        chk("sb_result", {26'h0, cw_c, cd_c}, {26'h0, sb_e.w, sb_e.d});
      end
    end
    chk("sb_one_grant", 64'($countones(rdy_c) > 1), 64'(0));
    for (int s = 0; s < 3; s++)
      if (vld[2][s] && rdy_c[s]) sb_q.push_back('{wid[2][s*6 +: 6], dat[2][s*32 +: 32]});
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic        fl;
    logic [4:0]  v;
    logic [29:0] w;
    logic [31:0] base;
    logic [4:0]  rdy;
    logic [1:0]  cv;
  } vec_t;
  vec_t tbl [10];

  task automatic clear_inputs();
    for (int i = 0; i < 3; i++) begin
      vld[i] = '0; wid[i] = '0; dat[i] = '0; fl[i] = 1'b0; done[i] = '0;
    end
  endtask

  task automatic reset_all();
    @(posedge clk); #1;
    rst_n = 1'b0;
    clear_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic drive_a(input vec_t e);
    fl[0] = e.fl;
    for (int s = 0; s < 5; s++) set_src(0, s, e.v[s], e.w[s*6 +: 6], e.base + 32'(17 * s));
  endtask

  logic [4:0] seq_v   [5];
  logic [4:0] seq_rdy [5];
  int         tag;

  initial begin
    for (int i = 0; i < 3; i++) begin
      for (int l = 0; l < 2; l++) m_ptr[i][l] = 0;
      for (int s = 0; s < 5; s++) m_cnt[i][s] = 0;
      e_cv[i] = '0; e_cw[i] = '0; e_cd[i] = '0; p_wait[i] = '0; p_wid[i] = '0;
    end
    clear_inputs();
    rst_n = 1'b0;
    tag   = 1;

    // Reset with every source requesting.
    for (int i = 0; i < 3; i++)
      for (int s = 0; s < np(i); s++) set_src(i, s, 1'b1, 6'(2 * s), 32'(s));
    repeat (2) begin
      @(negedge clk);
      chk("reset_ready_a", 64'(rdy_a), 64'(0));
      chk("reset_cdb_valid_a", 64'(cv_a), 64'(0));
      chk("reset_ready_c", 64'(rdy_c), 64'(0));
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_grant", 64'(rdy_a), 64'(5'b00001));
    @(negedge clk);
    chk("first_cdb_valid", 64'(cv_a), 64'(2'b01));

    // Directed table on the 5x2 instance: steering, round-robin, flush squash.
    tbl[0] = '{1'b0, 5'b00011, {6'h00, 6'h00, 6'h00, 6'h07, 6'h04}, 32'hAA,  5'b00011, 2'b11};
    tbl[1] = '{1'b0, 5'b11111, {6'h08, 6'h06, 6'h04, 6'h02, 6'h00}, 32'h100, 5'b00010, 2'b01};
    tbl[2] = '{1'b0, 5'b11111, {6'h08, 6'h06, 6'h04, 6'h02, 6'h00}, 32'h100, 5'b00100, 2'b01};
    tbl[3] = '{1'b1, 5'b11111, {6'h08, 6'h06, 6'h04, 6'h02, 6'h00}, 32'h100, 5'b00000, 2'b00};
    tbl[4] = '{1'b0, 5'b10001, {6'h08, 6'h06, 6'h04, 6'h02, 6'h00}, 32'h100, 5'b10000, 2'b01};
    tbl[5] = '{1'b0, 5'b01011, {6'h08, 6'h03, 6'h04, 6'h01, 6'h00}, 32'h100, 5'b01001, 2'b11};
    tbl[6] = '{1'b0, 5'b00110, {6'h08, 6'h03, 6'h05, 6'h01, 6'h00}, 32'h100, 5'b00010, 2'b10};
    tbl[7] = '{1'b0, 5'b00000, {6'h08, 6'h03, 6'h05, 6'h01, 6'h00}, 32'h100, 5'b00000, 2'b00};
    tbl[8] = '{1'b1, 5'b00100, {6'h08, 6'h03, 6'h01, 6'h01, 6'h00}, 32'h100, 5'b00000, 2'b00};
    tbl[9] = '{1'b0, 5'b00100, {6'h08, 6'h03, 6'h01, 6'h01, 6'h00}, 32'h100, 5'b00100, 2'b10};
    reset_all();
    for (int k = 0; k < 10; k++) begin
      drive_a(tbl[k]);
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", k), 64'(rdy_a), 64'(tbl[k].rdy));
      if (k > 0) chk($sformatf("tbl%0d_cdb_valid", k - 1), 64'(cv_a), 64'(tbl[k-1].cv));
      if (k == 1) begin
        chk("steer_wid", 64'(cw_a), 64'({6'h07, 6'h04}));
        chk("steer_data", cd_a, {32'hBB, 32'hAA});
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("tbl9_cdb_valid", 64'(cv_a), 64'(tbl[9].cv));

    // Round-robin with all five sources on lane 0; each advances to a new entry when granted.
    reset_all();
    for (int s = 0; s < 5; s++) set_src(0, s, 1'b1, 6'(2 * s), 32'(s));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("rr_cycle%0d", k), 64'(rdy_a), 64'(5'b00001 << (k % 5)));
      done[0] = rdy_a;
      @(posedge clk); #1;
      for (int s = 0; s < 5; s++)
        if (done[0][s]) set_src(0, s, 1'b1, 6'(2 * $urandom_range(0, 31)), $urandom);
    end

    // Starvation on the lim-2 instance: src3 waits behind the pointer and must be promoted.
    seq_v   = '{5'b01000, 5'b11000, 5'b11001, 5'b11010, 5'b01001};
    seq_rdy = '{5'b01000, 5'b10000, 5'b00001, 5'b01000, 5'b00001};
    reset_all();
    wid[1] = {6'd8, 6'd6, 6'd4, 6'd2, 6'd0};
    for (int k = 0; k < 5; k++) begin
      vld[1] = seq_v[k];
      dat[1] = {$urandom, $urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      chk($sformatf("starve_cycle%0d", k), 64'(rdy_s), 64'(seq_rdy[k]));
      @(posedge clk); #1;
    end

    // Long random run on all three instances; model and scoreboard check continuously.
    reset_all();
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < 3; i++) begin
        fl[i] = ($urandom_range(0, 15) == 0);
        for (int s = 0; s < np(i); s++)
          if (!vld[i][s] || done[i][s]) begin
            if ($urandom_range(0, 3) != 0) begin
              set_src(i, s, 1'b1, 6'($urandom_range(0, 63)), 32'(tag));
              tag++;
            end else begin
              vld[i][s] = 1'b0;
            end
          end
      end
      @(negedge clk);
      for (int i = 0; i < 3; i++) done[i] = vld[i] & o_rdy[i];
      @(posedge clk); #1;
    end
    clear_inputs();
    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
